// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 register-file emulator.
// Holds register address constants, Code-B font constants, the frame width
// and the receiver FSM state encoding.
package max7219_pkg;

  localparam int unsigned FrameWidth = 16;

  localparam logic [3:0] AddrNoop        = 4'h0;
  localparam logic [3:0] AddrDigit0      = 4'h1;
  localparam logic [3:0] AddrDigit1      = 4'h2;
  localparam logic [3:0] AddrDigit2      = 4'h3;
  localparam logic [3:0] AddrDigit3      = 4'h4;
  localparam logic [3:0] AddrDigit4      = 4'h5;
  localparam logic [3:0] AddrDigit5      = 4'h6;
  localparam logic [3:0] AddrDigit6      = 4'h7;
  localparam logic [3:0] AddrDigit7      = 4'h8;
  localparam logic [3:0] AddrDecodeMode  = 4'h9;
  localparam logic [3:0] AddrIntensity   = 4'hA;
  localparam logic [3:0] AddrScanLimit   = 4'hB;
  localparam logic [3:0] AddrShutdown    = 4'hC;
  localparam logic [3:0] AddrRsvdD       = 4'hD;
  localparam logic [3:0] AddrRsvdE       = 4'hE;
  localparam logic [3:0] AddrDisplayTest = 4'hF;

  localparam logic [3:0] CodeBDash  = 4'hA;
  localparam logic [3:0] CodeBBlank = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

endpackage

// File: rtl/code_b_font.sv
// Code-B font lookup: 4-bit code -> 7 segments ordered {A,B,C,D,E,F,G}.
// Ports:
//   i_code - Code-B character (0-9, A='-', B='E', C='H', D='L', E='P', F=blank)
//   o_seg  - segment enables, A in bit 6 down to G in bit 0
module code_b_font
  import max7219_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_code)
      4'h0:       o_seg = 7'h7E;
      4'h1:       o_seg = 7'h30;
      4'h2:       o_seg = 7'h6D;
      4'h3:       o_seg = 7'h79;
      4'h4:       o_seg = 7'h33;
      4'h5:       o_seg = 7'h5B;
      4'h6:       o_seg = 7'h5F;
      4'h7:       o_seg = 7'h70;
      4'h8:       o_seg = 7'h7F;
      4'h9:       o_seg = 7'h7B;
      CodeBDash:  o_seg = 7'h01;
      4'hB:       o_seg = 7'h4F;
      4'hC:       o_seg = 7'h37;
      4'hD:       o_seg = 7'h0E;
      4'hE:       o_seg = 7'h67;
      CodeBBlank: o_seg = 7'h00;
      default:    o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/max7219_rx.sv
// SPI receiver emulating the MAX7219 register file in the system clock domain.
// SCLK/MOSI/CS_N are oversampled; 16-bit frames are shifted in MSB first and
// decoded on each CS_N rise.
// Ports:
//   clk, rst                       - system clock, async active-high reset
//   spi_sclk, spi_mosi, spi_cs_n   - asynchronous SPI pins
//   frame_valid / frame_err        - one-cycle pulses per accepted / short frame
//   frame_addr, frame_data         - fields of the last accepted frame
//   digit_regs .. display_test     - emulated register file
//   seg_flat                       - decoded segments, only when MAX7219_RX_SEGOUT_EN
//                                    is defined
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_err,
  output logic [63:0] digit_regs,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown,
`ifdef MAX7219_RX_SEGOUT_EN
  output logic [63:0] seg_flat,
`endif
  output logic        display_test
);

  localparam logic [4:0] CountFull = 5'(FrameWidth);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_hist, r_cs_hist;
  logic                   w_sclk_s, w_mosi_s, w_cs_s;
  logic                   w_sclk_rise, w_cs_rise, w_cs_fall;

  // cs_n chain and history reset high so an already-low pin yields a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_hist <= w_sclk_s;
      r_cs_hist   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_cs_rise   = w_cs_s & ~r_cs_hist;
  assign w_cs_fall   = ~w_cs_s & r_cs_hist;

  state_e r_state, w_state_d;
  logic   w_clear, w_shift, w_latch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_shift   = 1'b0;
    w_latch   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_cs_fall) begin
          w_clear   = 1'b1;
          w_state_d = StShift;
        end
      end
      StShift: begin
        // A simultaneous sclk rise is dropped: the frame is already closed.
        if (w_cs_rise)        w_state_d = StLatch;
        else if (w_sclk_rise) w_shift   = 1'b1;
      end
      StLatch: begin
        w_latch = 1'b1;
        if (w_cs_fall) begin
          w_clear   = 1'b1;
          w_state_d = StShift;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  logic [15:0] r_shreg;
  logic [4:0]  r_count;
  logic [3:0]  w_addr;
  logic [2:0]  w_digit_idx;
  logic        w_unused;

  assign w_addr      = r_shreg[11:8];
  assign w_digit_idx = 3'(w_addr - 4'd1);
  assign w_unused    = ^r_shreg[15:12];

  logic        r_frame_valid, r_frame_err;
  logic [3:0]  r_frame_addr;
  logic [7:0]  r_frame_data;
  logic [63:0] r_digit_regs;
  logic [7:0]  r_decode_mode;
  logic [3:0]  r_intensity;
  logic [2:0]  r_scan_limit;
  logic        r_shutdown;
  logic        r_display_test;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg        <= '0;
      r_count        <= '0;
      r_frame_valid  <= 1'b0;
      r_frame_err    <= 1'b0;
      r_frame_addr   <= '0;
      r_frame_data   <= '0;
      r_digit_regs   <= '0;
      r_decode_mode  <= '0;
      r_intensity    <= '0;
      r_scan_limit   <= '0;
      r_shutdown     <= 1'b1;
      r_display_test <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (w_clear) begin
        r_shreg <= '0;
        r_count <= '0;
      end else if (w_shift) begin
        // Keeps the last 16 bits, so long frames behave like a daisy chain.
        r_shreg <= {r_shreg[14:0], w_mosi_s};
        if (r_count != CountFull) r_count <= r_count + 5'd1;
      end
      if (w_latch) begin
        if (r_count < CountFull) begin
          r_frame_err <= 1'b1;
        end else begin
          r_frame_valid <= 1'b1;
          r_frame_addr  <= w_addr;
          r_frame_data  <= r_shreg[7:0];
          case (w_addr)
            AddrDigit0, AddrDigit1, AddrDigit2, AddrDigit3,
            AddrDigit4, AddrDigit5, AddrDigit6, AddrDigit7:
              r_digit_regs[{w_digit_idx, 3'b000} +: 8] <= r_shreg[7:0];
            AddrDecodeMode:  r_decode_mode  <= r_shreg[7:0];
            AddrIntensity:   r_intensity    <= r_shreg[3:0];
            AddrScanLimit:   r_scan_limit   <= r_shreg[2:0];
            AddrShutdown:    r_shutdown     <= ~r_shreg[0];
            AddrDisplayTest: r_display_test <= r_shreg[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign frame_valid  = r_frame_valid;
  assign frame_err    = r_frame_err;
  assign frame_addr   = r_frame_addr;
  assign frame_data   = r_frame_data;
  assign digit_regs   = r_digit_regs;
  assign decode_mode  = r_decode_mode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan_limit;
  assign shutdown     = r_shutdown;
  assign display_test = r_display_test;

`ifdef MAX7219_RX_SEGOUT_EN
  logic [6:0] w_font [8];

  for (genvar n = 0; n < 8; n++) begin : g_font
    code_b_font u_font (
      .i_code (r_digit_regs[8*n +: 4]),
      .o_seg  (w_font[n])
    );
  end

  always_comb begin
    seg_flat = '0;
    for (int n = 0; n < 8; n++) begin
      if (r_display_test)      seg_flat[8*n +: 8] = 8'hFF;
      else if (r_shutdown)     seg_flat[8*n +: 8] = 8'h00;
      else if (r_decode_mode[n]) seg_flat[8*n +: 8] = {r_digit_regs[8*n+7], w_font[n]};
      else                     seg_flat[8*n +: 8] = r_digit_regs[8*n +: 8];
    end
  end
`endif

endmodule

// File: tb/tb_max7219_rx.sv
module tb_max7219_rx;
  import max7219_pkg::*;

  localparam int unsigned SyncStages = 2;
  localparam int          HalfSclk   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        frame_valid, frame_err;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic [63:0] digit_regs;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown, display_test;
`ifdef MAX7219_RX_SEGOUT_EN
  logic [63:0] seg_flat;
`endif

  max7219_rx #(.SYNC_STAGES(SyncStages)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .frame_valid  (frame_valid),
    .frame_addr   (frame_addr),
    .frame_data   (frame_data),
    .frame_err    (frame_err),
    .digit_regs   (digit_regs),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown     (shutdown),
`ifdef MAX7219_RX_SEGOUT_EN
    .seg_flat     (seg_flat),
`endif
    .display_test (display_test)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent model of the register file.
  logic [63:0] m_digit;
  logic [7:0]  m_decode;
  logic [3:0]  m_intensity;
  logic [2:0]  m_scan;
  logic        m_shutdown, m_test;
  logic [3:0]  m_faddr;
  logic [7:0]  m_fdata;
  int          exp_valid = 0, exp_err = 0, n_valid = 0, n_err = 0;

  typedef struct packed {
    logic       err;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    m_digit = '0; m_decode = '0; m_intensity = '0; m_scan = '0;
    m_shutdown = 1'b1; m_test = 1'b0; m_faddr = '0; m_fdata = '0;
    sb.delete();
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    m_faddr = a;
    m_fdata = d;
    if (a >= 4'h1 && a <= 4'h8) m_digit[(int'(a) - 1) * 8 +: 8] = d;
    else if (a == 4'h9) m_decode = d;
    else if (a == 4'hA) m_intensity = d[3:0];
    else if (a == 4'hB) m_scan = d[2:0];
    else if (a == 4'hC) m_shutdown = ~d[0];
    else if (a == 4'hF) m_test = d[0];
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".digit"}, digit_regs, m_digit);
    chk({tag, ".decode"}, 64'(decode_mode), 64'(m_decode));
    chk({tag, ".intensity"}, 64'(intensity), 64'(m_intensity));
    chk({tag, ".scan"}, 64'(scan_limit), 64'(m_scan));
    chk({tag, ".shutdown"}, 64'(shutdown), 64'(m_shutdown));
    chk({tag, ".test"}, 64'(display_test), 64'(m_test));
    chk({tag, ".faddr"}, 64'(frame_addr), 64'(m_faddr));
    chk({tag, ".fdata"}, 64'(frame_data), 64'(m_fdata));
  endtask

  // Scoreboard consumer: every pulse pops one expected frame.
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      exp_t e;
      if (frame_valid) n_valid++;
      if (frame_err)   n_err++;
      chk("sb.pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb.valid", 64'(frame_valid), 64'(!e.err));
        chk("sb.err", 64'(frame_err), 64'(e.err));
        chk("sb.addr", 64'(frame_addr), 64'(e.addr));
        chk("sb.data", 64'(frame_data), 64'(e.data));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise CS_N and measure pin-to-pulse latency in clk edges.
  task automatic close_frame(input string tag);
    int lat;
    spi_cs_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid || frame_err) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, 64'(lat), 64'(SyncStages + 2));
    wait_clk(10);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] bits, input int nbits);
    exp_t e;
    spi_cs_n = 1'b0;
    wait_clk(HalfSclk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      wait_clk(HalfSclk);
      spi_sclk = 1'b1;
      wait_clk(HalfSclk);
      spi_sclk = 1'b0;
    end
    wait_clk(HalfSclk);
    if (nbits < FrameWidth) begin
      e = '{err: 1'b1, addr: m_faddr, data: m_fdata};
      exp_err++;
    end else begin
      model_write(bits[11:8], bits[7:0]);
      e = '{err: 1'b0, addr: bits[11:8], data: bits[7:0]};
      exp_valid++;
    end
    sb.push_back(e);
    close_frame(tag);
  endtask

  initial begin
    model_reset();
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check_regs("reset");
    chk("reset.valid", 64'(frame_valid), 64'd0);
    chk("reset.err", 64'(frame_err), 64'd0);

    // Control registers
    send_frame("ctl0", 32'h09FF, 16);
    send_frame("ctl1", 32'h0B07, 16);
    send_frame("ctl2", 32'h0A08, 16);
    send_frame("ctl3", 32'h0C01, 16);
    send_frame("ctl4", 32'h0F00, 16);
    check_regs("ctl");
    chk("ctl.nvalid", 64'(n_valid), 64'd5);

    // Digits
    send_frame("dig0", 32'h0305, 16);
    send_frame("dig1", 32'h0809, 16);
    check_regs("dig");
    chk("dig.d2", 64'(digit_regs[23:16]), 64'h05);
    chk("dig.d7", 64'(digit_regs[63:56]), 64'h09);

    // Short frame
    send_frame("short", 32'h01AB, 12);
    check_regs("short");
    chk("short.nerr", 64'(n_err), 64'd1);

    // Daisy-chained long frame
    send_frame("long", 32'hAB0107, 24);
    check_regs("long");
    chk("long.d0", 64'(digit_regs[7:0]), 64'h07);

    // Reset mid-frame after 9 bits of 0x0155
    spi_cs_n = 1'b0;
    wait_clk(HalfSclk);
    for (int i = 15; i >= 7; i--) begin
      logic [15:0] w;
      w = 16'h0155;
      spi_mosi = w[i];
      wait_clk(HalfSclk);
      spi_sclk = 1'b1;
      wait_clk(HalfSclk);
      spi_sclk = 1'b0;
    end
    rst = 1'b1;
    model_reset();
    wait_clk(3);
    spi_cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    check_regs("midrst");
    send_frame("noop_d", 32'h0D33, 16);
    send_frame("noop_0", 32'h0033, 16);
    check_regs("noop");

    // Reset released while CS_N already low: empty frame ends in an error
    rst = 1'b1;
    model_reset();
    spi_cs_n = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    sb.push_back('{err: 1'b1, addr: 4'h0, data: 8'h00});
    exp_err++;
    close_frame("rstlow");
    check_regs("rstlow");

`ifdef MAX7219_RX_SEGOUT_EN
    send_frame("seg0", 32'h0C01, 16);
    send_frame("seg1", 32'h09FF, 16);
    send_frame("seg2", 32'h030A, 16);
    send_frame("seg3", 32'h0188, 16);
    chk("seg.b2", 64'(seg_flat[23:16]), 64'h01);
    chk("seg.b0", 64'(seg_flat[7:0]), 64'hFF);
    chk("seg.b1", 64'(seg_flat[15:8]), 64'h7E);
    send_frame("seg4", 32'h0900, 16);
    chk("seg.raw0", 64'(seg_flat[7:0]), 64'h88);
    chk("seg.raw2", 64'(seg_flat[23:16]), 64'h0A);
    send_frame("seg5", 32'h0F01, 16);
    chk("seg.test", seg_flat, 64'hFFFF_FFFF_FFFF_FFFF);
    send_frame("seg6", 32'h0F00, 16);
    send_frame("seg7", 32'h0C00, 16);
    chk("seg.shdn", seg_flat, 64'h0);
    check_regs("seg");
`endif

    chk("end.sb_empty", 64'(sb.size()), 64'd0);
    chk("end.nvalid", 64'(n_valid), 64'(exp_valid));
    chk("end.nerr", 64'(n_err), 64'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
